// File: rtl/prgen_fifo_pkg.sv
// Shared sizing helpers for the prgen FIFO: clog2 plus pointer and level width derivation.
package prgen_fifo_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    // Storage behind the output register; DEPTH=1 keeps a dummy single entry.
    function automatic int mem_depth(input int depth);
        return (depth > 1) ? depth - 1 : 1;
    endfunction

    function automatic int ptr_width(input int entries);
        return (entries > 1) ? clog2(entries) : 1;
    endfunction

    function automatic int level_width(input int depth);
        return clog2(depth + 1);
    endfunction

endpackage

// File: rtl/prgen_fifo_ptr.sv
// Wrapping pointer counter: counts 0..LAST and then returns to 0.
module prgen_fifo_ptr
    import prgen_fifo_pkg::*;
#(
    parameter int LAST = 6,
    localparam int PTR_W = ptr_width(LAST + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == PTR_W'(LAST)) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/prgen_fifo_ext.sv
// Synchronous FIFO with registered first-word-fall-through output, flush and threshold flags.
// Define PRGEN_FIFO_ERR_EN to enable sticky overflow/underflow flags.
module prgen_fifo_ext
    import prgen_fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    localparam int LEVEL_W = level_width(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               push,
    input  logic [WIDTH-1:0]   din,
    input  logic               pop,
    input  logic               err_clr,
    output logic [WIDTH-1:0]   dout,
    output logic               empty,
    output logic               full,
    output logic [LEVEL_W-1:0] level,
    output logic               almost_full,
    output logic               almost_empty,
    output logic               overflow,
    output logic               underflow
);

    localparam int MEM_D = mem_depth(DEPTH);
    localparam int PTR_W = ptr_width(MEM_D);

    logic [WIDTH-1:0]   mem [MEM_D];
    logic [WIDTH-1:0]   dout_q;
    logic               out_valid;
    logic [LEVEL_W-1:0] level_q;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic               mem_empty;
    logic               push_ok;
    logic               pop_ok;
    logic               mem_wr;
    logic               mem_rd;

    assign empty        = !out_valid;
    assign full         = (level_q == LEVEL_W'(DEPTH));
    assign almost_full  = (int'(level_q) >= AF_LEVEL);
    assign almost_empty = (int'(level_q) <= AE_LEVEL);
    assign level        = level_q;
    assign dout         = dout_q;

    // Words held in the array = level minus the one sitting in the output register.
    assign mem_empty = ((level_q - LEVEL_W'(out_valid)) == '0);

    assign push_ok = push && (!full || pop) && !flush;
    assign pop_ok  = pop && out_valid && !flush;

    // A push bypasses the array when the output register is free or is being emptied.
    assign mem_wr = push_ok && out_valid && !(pop_ok && mem_empty);
    assign mem_rd = pop_ok && !mem_empty;

    // NOTE: the storage array is not reset; pointers and level alone define validity.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            dout_q    <= '0;
            out_valid <= 1'b0;
        end else if (pop_ok) begin
            if (!mem_empty) begin
                dout_q <= mem[rd_ptr];
            end else if (push_ok) begin
                dout_q <= din;
            end else begin
                dout_q    <= '0;
                out_valid <= 1'b0;
            end
        end else if (push_ok && !out_valid) begin
            dout_q    <= din;
            out_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            level_q <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    prgen_fifo_ptr #(.LAST(MEM_D - 1)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (mem_wr),
        .ptr (wr_ptr)
    );

    prgen_fifo_ptr #(.LAST(MEM_D - 1)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (mem_rd),
        .ptr (rd_ptr)
    );

`ifdef PRGEN_FIFO_ERR_EN
    logic ovf_set;
    logic unf_set;

    assign ovf_set = push && full && !pop && !flush;
    assign unf_set = pop && !out_valid && !flush;

    // Setting takes precedence over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (unf_set) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_prgen_fifo_ext.sv
// Randomized self-checking bench for prgen_fifo_ext against a queue-based reference model.
module tb_prgen_fifo_ext;

    localparam int WIDTH    = 8;
    localparam int DEPTH    = 4;
    localparam int AF_LEVEL = 3;
    localparam int AE_LEVEL = 1;
    localparam int LEVEL_W  = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               flush = 1'b0;
    logic               push = 1'b0;
    logic [WIDTH-1:0]   din = '0;
    logic               pop = 1'b0;
    logic               err_clr = 1'b0;
    logic [WIDTH-1:0]   dout;
    logic               empty;
    logic               full;
    logic [LEVEL_W-1:0] level;
    logic               almost_full;
    logic               almost_empty;
    logic               overflow;
    logic               underflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: contents in arrival order plus sticky flags.
    logic [WIDTH-1:0] model_q[$];
    logic             m_ovf = 1'b0;
    logic             m_unf = 1'b0;

`ifdef PRGEN_FIFO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    prgen_fifo_ext #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL),
        .AE_LEVEL (AE_LEVEL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .push         (push),
        .din          (din),
        .pop          (pop),
        .err_clr      (err_clr),
        .dout         (dout),
        .empty        (empty),
        .full         (full),
        .level        (level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_cycle(input logic p, input logic [WIDTH-1:0] d, input logic po,
                               input logic fl, input logic ec, input logic rs);
        int  n;
        bit  was_full;
        bit  was_empty;
        n         = model_q.size();
        was_full  = (n == DEPTH);
        was_empty = (n == 0);
        if (rs) begin
            model_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (ERR_EN) begin
                if (p && was_full && !po && !fl) m_ovf = 1'b1;
                else if (ec)                     m_ovf = 1'b0;
                if (po && was_empty && !fl)      m_unf = 1'b1;
                else if (ec)                     m_unf = 1'b0;
            end
            if (fl) begin
                model_q.delete();
            end else begin
                if (po && !was_empty) void'(model_q.pop_front());
                if (p && (!was_full || po)) model_q.push_back(d);
            end
        end
    endtask

    task automatic compare_all(input string name);
        int n;
        n = model_q.size();
        check({name, " dout"},  32'(dout),         (n > 0) ? 32'(model_q[0]) : 32'd0);
        check({name, " level"}, 32'(level),        32'(n));
        check({name, " empty"}, 32'(empty),        32'(n == 0));
        check({name, " full"},  32'(full),         32'(n == DEPTH));
        check({name, " af"},    32'(almost_full),  32'(n >= AF_LEVEL));
        check({name, " ae"},    32'(almost_empty), 32'(n <= AE_LEVEL));
        check({name, " ovf"},   32'(overflow),     32'(m_ovf));
        check({name, " unf"},   32'(underflow),    32'(m_unf));
    endtask

    task automatic step(input string name, input logic p, input logic [WIDTH-1:0] d,
                        input logic po, input logic fl = 1'b0, input logic ec = 1'b0,
                        input logic rs = 1'b0);
        @(negedge clk);
        push    = p;
        din     = d;
        pop     = po;
        flush   = fl;
        err_clr = ec;
        rst     = rs;
        model_cycle(p, d, po, fl, ec, rs);
        @(posedge clk);
        #1;
        compare_all(name);
    endtask

    initial begin
        step("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        step("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        step("idle",  1'b0, 8'h00, 1'b0);

        // Single push into empty, then drain.
        step("push11", 1'b1, 8'h11, 1'b0);
        step("pop11",  1'b0, 8'h00, 1'b1);

        // Fill, overflow attempt, drain in order.
        for (int i = 1; i <= 4; i++) step("fill", 1'b1, 8'(i), 1'b0);
        step("ovf", 1'b1, 8'h05, 1'b0);
        for (int i = 0; i < 5; i++) step("drain", 1'b0, 8'h00, 1'b1);
        step("clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Push and pop together while full.
        for (int i = 1; i <= 4; i++) step("fill2", 1'b1, 8'(8'h20 + i), 1'b0);
        step("fullpp", 1'b1, 8'hAA, 1'b1);
        for (int i = 0; i < 4; i++) step("drain2", 1'b0, 8'h00, 1'b1);

        // Steady level 2 across pointer wrap.
        step("lvl2a", 1'b1, 8'h30, 1'b0);
        step("lvl2b", 1'b1, 8'h31, 1'b0);
        for (int i = 0; i < 10; i++) step("wrap", 1'b1, 8'(8'h40 + i), 1'b1);
        step("wrapd", 1'b0, 8'h00, 1'b1);
        step("wrapd", 1'b0, 8'h00, 1'b1);

        // Flush at level 3 with a concurrent push.
        for (int i = 0; i < 3; i++) step("pref", 1'b1, 8'(8'h50 + i), 1'b0);
        step("flush", 1'b1, 8'h5F, 1'b0, 1'b1);
        step("postfl", 1'b1, 8'h60, 1'b0);
        step("postfl", 1'b0, 8'h00, 1'b1);

        // Underflow, push+pop on empty, error clear with coincident set, reset mid-fill.
        step("unf",     1'b0, 8'h00, 1'b1);
        step("unfpp",   1'b1, 8'h70, 1'b1);
        step("unfset",  1'b0, 8'h00, 1'b1);
        step("unfset2", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        step("errclr",  1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step("mid1",    1'b1, 8'h71, 1'b0);
        step("mid2",    1'b1, 8'h72, 1'b0);
        step("midrst",  1'b1, 8'h73, 1'b1, 1'b1, 1'b1, 1'b1);
        step("afterrst", 1'b0, 8'h00, 1'b0);

        // Randomized traffic, biased toward keeping the queue partly filled.
        for (int i = 0; i < 800; i++) begin
            logic p, po, fl, ec, rs;
            p  = ($urandom_range(99) < 55);
            po = ($urandom_range(99) < 45);
            fl = ($urandom_range(99) < 3);
            ec = ($urandom_range(99) < 6);
            rs = ($urandom_range(199) < 1);
            step("rand", p, 8'($urandom), po, fl, ec, rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
